// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: parse states, ASCII constants and hex helpers for uart_cmd_parser
package uart_cmd_pkg;
    typedef enum logic [2:0] {P_CMD, P_ARG, P_END_L, P_END_R, P_SKIP, P_RESP} p_state_t;
    typedef struct packed {
        logic       vld;
        logic [3:0] nib;
    } hex_t;
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    function automatic hex_t hex2nib(input logic [7:0] c);
        hex_t r;
        r = '0;
        if (c >= 8'h30 && c <= 8'h39) r = '{vld: 1'b1, nib: c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            r = '{vld: 1'b1, nib: c[3:0] + 4'd9};
        return r;
    endfunction
    function automatic logic [7:0] nib2hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
endpackage

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: drains the RX FIFO, decodes "L<h>\r" / "R\r" frames,
// drives the LED register and writes one response byte per frame to the TX FIFO.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_empty_i,
    output logic                  rx_ren_o,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  tx_full_i,
    output logic                  tx_wen_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic [3:0]            led_o,
    output logic [7:0]            err_cnt_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    p_state_t      state, next;
    logic          in_flight, byte_vld, timed, expire, err_inc, set_led, load_resp;
    logic [TW-1:0] cnt;
    logic [3:0]    nib;
    logic [7:0]    resp;
    hex_t          h;

    // a read is issued only when its byte can be consumed; data lands one cycle later
    assign byte_vld = in_flight;
    assign rx_ren_o = !rst_i && !rx_empty_i && !in_flight && state != P_RESP;
    assign tx_wen_o = !rst_i && state == P_RESP && !tx_full_i;
    assign timed    = state inside {P_ARG, P_END_L, P_END_R, P_SKIP};
    assign expire   = timed && !byte_vld && cnt == TW'(TIMEOUT_CYCLES - 1);
    assign h        = hex2nib(rx_data_i);
    assign resp     = state == P_END_L ? CH_K : state == P_END_R ? nib2hex(led_o) : CH_E;

    always_comb begin
        next    = state;
        err_inc = expire;
        set_led = 1'b0;
        if (expire) next = P_CMD;
        else if (byte_vld) begin
            case (state)
                P_CMD:   next = rx_data_i == CH_L ? P_ARG : rx_data_i == CH_R ? P_END_R :
                                (rx_data_i == CH_CR || rx_data_i == CH_LF) ? P_CMD : P_SKIP;
                P_ARG:   next = h.vld ? P_END_L : P_SKIP;
                P_END_L: begin
                    next    = rx_data_i == CH_CR ? P_RESP : P_SKIP;
                    set_led = rx_data_i == CH_CR;
                end
                P_END_R: next = rx_data_i == CH_CR ? P_RESP : P_SKIP;
                P_SKIP:  begin
                    next    = rx_data_i == CH_CR ? P_RESP : P_SKIP;
                    err_inc = rx_data_i == CH_CR;
                end
                default: next = state;
            endcase
        end
        if (tx_wen_o) next = P_CMD;
        load_resp = next == P_RESP && state != P_RESP;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= P_CMD;
            in_flight <= 1'b0;
            cnt       <= '0;
            nib       <= '0;
            led_o     <= '0;
            tx_data_o <= '0;
            err_cnt_o <= '0;
        end else begin
            state     <= next;
            in_flight <= rx_ren_o;
            cnt       <= (timed && !byte_vld && !expire) ? cnt + 1'b1 : '0;
            if (state == P_ARG && byte_vld) nib <= h.nib;
            if (set_led) led_o <= nib;
            if (load_resp) tx_data_o <= resp;
            if (err_inc && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed frames through an RX FIFO model with a TX write monitor
module tb_uart_cmd_parser;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_empty, rx_ren, tx_full = 1'b0, tx_wen;
    logic [7:0] rx_data = '0, tx_data;
    logic [3:0] led;
    logic [7:0] err_cnt;

    logic [7:0] mem [0:255];
    int wp = 0, rp = 0;
    int cyc = 0, cr_cyc = 0, wen_cyc = 0, tx_cnt = 0, ren_cnt = 0;
    logic [7:0] tx_last = '0;
    int n_cmp = 0, n_bad = 0;
    int ren_mark;

    uart_cmd_parser #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(20)) dut (
        .clk_i(clk), .rst_i(rst), .rx_empty_i(rx_empty), .rx_ren_o(rx_ren),
        .rx_data_i(rx_data), .tx_full_i(tx_full), .tx_wen_o(tx_wen),
        .tx_data_o(tx_data), .led_o(led), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;
    assign rx_empty = (wp == rp);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_ren) begin
            rx_data <= mem[rp[7:0]];
            rp      <= rp + 1;
            ren_cnt <= ren_cnt + 1;
            if (mem[rp[7:0]] == 8'h0D) cr_cyc <= cyc;
        end
        if (tx_wen) begin
            tx_cnt  <= tx_cnt + 1;
            tx_last <= tx_data;
            wen_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp[7:0]] = b;
        wp = wp + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx(input int target, input string tag);
        for (int i = 0; i < 300 && tx_cnt < target; i++) @(negedge clk);
        check(tag, tx_cnt, target);
    endtask

    initial begin
        idle(3);
        check("rst_led", led, 0);
        check("rst_err", err_cnt, 0);
        check("rst_txd", tx_data, 0);
        check("rst_wen", tx_wen, 0);
        rst = 1'b0;

        push(8'h4C); push(8'h41); push(8'h0D);
        wait_tx(1, "la_tx");
        idle(2);
        check("la_led", led, 4'hA);
        check("la_data", tx_last, 8'h4B);
        check("la_err", err_cnt, 0);
        check("la_latency", wen_cyc - cr_cyc, 2);

        push(8'h52); push(8'h0D);
        wait_tx(2, "r_tx");
        idle(2);
        check("r_data", tx_last, 8'h41);
        check("r_led", led, 4'hA);

        push(8'h4C); push(8'h47); push(8'h31); push(8'h0D);
        wait_tx(3, "bad_tx");
        idle(10);
        check("bad_data", tx_last, 8'h45);
        check("bad_err", err_cnt, 1);
        check("bad_led", led, 4'hA);
        check("bad_once", tx_cnt, 3);
        push(8'h4C); push(8'h35); push(8'h0D);
        wait_tx(4, "l5_tx");
        idle(2);
        check("l5_led", led, 4'h5);
        check("l5_data", tx_last, 8'h4B);

        tx_full = 1'b1;
        push(8'h4C); push(8'h39); push(8'h0D); push(8'h52); push(8'h0D);
        idle(20);
        ren_mark = ren_cnt;
        check("full_txd_early", tx_data, 8'h4B);
        idle(80);
        check("full_wen", tx_wen, 0);
        check("full_cnt", tx_cnt, 4);
        check("full_noread", ren_cnt, ren_mark);
        check("full_txd", tx_data, 8'h4B);
        check("full_led", led, 4'h9);
        tx_full = 1'b0;
        wait_tx(5, "rel_tx");
        idle(1);
        check("rel_data", tx_last, 8'h4B);
        wait_tx(6, "rel_r_tx");
        idle(10);
        check("rel_r_data", tx_last, 8'h39);
        check("rel_total", tx_cnt, 6);

        push(8'h4C);
        idle(30);
        check("to_err", err_cnt, 2);
        check("to_notx", tx_cnt, 6);
        check("to_led", led, 4'h9);
        push(8'h4C); push(8'h33); push(8'h0D);
        wait_tx(7, "l3_tx");
        idle(2);
        check("l3_led", led, 4'h3);
        check("l3_data", tx_last, 8'h4B);
        check("l3_err", err_cnt, 2);

        push(8'h4C); push(8'h66); push(8'h0D);
        wait_tx(8, "lf_tx");
        push(8'h52); push(8'h0D);
        wait_tx(9, "rf_tx");
        idle(2);
        check("lf_led", led, 4'hF);
        check("rf_data", tx_last, 8'h46);

        push(8'h4C);
        idle(4);
        rst = 1'b1;
        push(8'h37); push(8'h0D);
        idle(1);
        check("mrst_led", led, 0);
        check("mrst_err", err_cnt, 0);
        check("mrst_txd", tx_data, 0);
        check("mrst_wen", tx_wen, 0);
        check("mrst_ren", rx_ren, 0);
        rst = 1'b0;
        wait_tx(10, "mrst_tx");
        idle(10);
        check("mrst_data", tx_last, 8'h45);
        check("mrst_led2", led, 0);
        check("mrst_err2", err_cnt, 1);
        check("mrst_once", tx_cnt, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
